keypad_excess3_ctrl: RTL
========================

KEYPAD_EXCESS3_CTRL -- requirements
Module: keypad_excess3_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples needed to accept a press or a release (legal range 2..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: depth of the key-code buffer (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port key  input  10  raw key lines from the decimal keypad, asynchronous to clk; bit k = digit k.
REQ-006 SHALL have port ready  input  1  consumer accepts code_out this cycle.
REQ-007 SHALL have port clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-008 SHALL have port code_out  output  4  excess-3 code at the buffer head; 4'd0 when the buffer is empty.
REQ-009 SHALL have port valid  output  1  buffer not empty.
REQ-010 SHALL have port count  output  4  number of buffered codes, 0..FIFO_DEPTH.
REQ-011 SHALL have port key_down  output  1  high in states HELD and RELEASE.
REQ-012 SHALL have port overflow  output  1  sticky flag: an accepted press was dropped because the buffer was full.

Function
REQ-013 SHALL pass key through a 2-flop synchronizer; ks is the synchronized vector and the only key view used downstream.
REQ-014 SHALL encode by priority, highest set bit wins: digit k -> k+3 (key[9] -> 12, key[0] -> 3); all-zero -> 0 (never pushed).
REQ-015 SHALL implement FSM IDLE, DEBOUNCE, HELD, RELEASE; it holds a snapshot register snap[9:0] and a counter cnt.
REQ-016 IDLE: ks==0 stays; ks!=0 -> DEBOUNCE with snap=ks and cnt=0.
REQ-017 DEBOUNCE: ks==0 -> IDLE; ks nonzero and !=snap -> stay, snap=ks, cnt=0; ks==snap and cnt==DEBOUNCE_CYCLES-1 -> push encode(snap), go to HELD; otherwise cnt+1.
REQ-018 HELD: ks!=0 stays with no further pushes, even if the key pattern changes; ks==0 -> RELEASE with cnt=0.
REQ-019 RELEASE: ks!=0 -> HELD; ks==0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; otherwise cnt+1.
REQ-020 Latency: a press held stable from clk edge 1 (first sampling edge) SHALL give valid=1 after edge DEBOUNCE_CYCLES+3.
REQ-021 Pop SHALL occur when valid && ready; code_out and valid SHALL reflect the new head in the next cycle.
REQ-022 Push while full and no pop: the code SHALL be dropped, overflow set, and count unchanged.
REQ-023 Simultaneous push and pop while full: both SHALL take effect; overflow unchanged and count stays FIFO_DEPTH.
REQ-024 Simultaneous push and pop while empty: the push SHALL occur and the pop SHALL be ignored, because valid was 0.
REQ-025 clr_ovf SHALL clear overflow; if an overflow event occurs in the same cycle, set wins.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH or underflow.

Reset
REQ-027 While rst_n=0, the block SHALL hold state=IDLE, synchronizer=0, snap=0, cnt=0, FIFO empty, and code_out=0, valid=0, count=0, key_down=0, overflow=0.
REQ-028 Reset asserted mid-debounce or mid-hold SHALL discard all state; a key held through reset release SHALL be debounced afresh and emitted once.
REQ-029 Reset deassertion SHALL be synchronized externally; the block performs no internal reset synchronization.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the excess-3 offset constant 3, and the empty-code constant 4'd0.
REQ-031 Priority encoding SHALL be done by instantiating the existing encoder_3cyclic sub-module on snap; no duplicate encoder logic.
REQ-032 The FIFO SHALL stay inline, as registers plus pointers; no separate sub-module is required.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-033 key=10'h020 held 20 cycles, ready=0 -> valid=1 after edge 7, code_out=8, count=1, key_down=1; after release and 4 quiet cycles -> key_down=0, and no second push.
REQ-034 key=10'h001 toggled every 2 cycles for 20 cycles -> valid stays 0, count=0.
REQ-035 key=10'h204 (digits 9 and 2) held -> code_out=12; digit 2 alone pressed afterwards -> second entry 5.
REQ-036 Five distinct presses (digits 0,1,2,3,4), ready=0 -> count=4, overflow=1; pops give 3,4,5,6; clr_ovf -> overflow=0.
REQ-037 FIFO full with a press completing in the same cycle that ready=1 pops -> count=4, overflow=0, and the new code is last out.
REQ-038 rst_n pulsed low mid-DEBOUNCE with key held -> all outputs 0 during reset; after release exactly one code is emitted, DEBOUNCE_CYCLES+3 edges later.

Source files
------------

// File: rtl/keypad_excess3_ctrl_pkg.sv
// Shared definitions for the keypad excess-3 controller.
//   state_e        : debounce FSM state encoding
//   EXCESS3_OFFSET : added to the decimal digit to form the excess-3 code
//   EMPTY_CODE     : code presented when nothing is buffered
package keypad_excess3_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    localparam logic [3:0] EXCESS3_OFFSET = 4'd3;
    localparam logic [3:0] EMPTY_CODE     = 4'd0;

endpackage

// File: rtl/keypad_excess3_ctrl_encoder.sv
// encoder_3cyclic: priority encoder from a 10-line decimal key vector to
// excess-3. The highest set bit wins; no bits set yields EMPTY_CODE.
//   keys : key vector, bit k = digit k
//   code : excess-3 code of the highest pressed digit, or 0
module encoder_3cyclic
    import keypad_excess3_ctrl_pkg::*;
(
    input  logic [9:0] keys,
    output logic [3:0] code
);

    // Ascending scan so that a later (higher) set bit overrides lower ones.
    always_comb begin
        code = EMPTY_CODE;
        for (int k = 0; k < 10; k++) begin
            if (keys[k]) code = 4'(k) + EXCESS3_OFFSET;
        end
    end

endmodule

// File: rtl/keypad_excess3_ctrl.sv
// keypad_excess3_ctrl: synchronizes and debounces a 10-key decimal keypad,
// emits one excess-3 code per accepted press into a small FIFO.
//   clk, rst_n : clock, async active-low reset (deassertion synced externally)
//   key        : raw asynchronous key lines, bit k = digit k
//   ready      : consumer takes code_out this cycle (pop when valid)
//   clr_ovf    : clear the sticky overflow flag
//   code_out   : head-of-buffer code, 0 when empty
//   valid      : buffer not empty
//   count      : buffered code count, 0..FIFO_DEPTH
//   key_down   : a press has been accepted and not yet fully released
//   overflow   : sticky, an accepted press was lost to a full buffer
module keypad_excess3_ctrl
    import keypad_excess3_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] key,
    input  logic       ready,
    input  logic       clr_ovf,
    output logic [3:0] code_out,
    output logic       valid,
    output logic [3:0] count,
    output logic       key_down,
    output logic       overflow
);

    localparam int         PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] DEPTH_C  = 4'(FIFO_DEPTH);

    // ---------------- synchronizer ----------------
    logic [9:0] sync1_q, ks_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            ks_q    <= '0;
        end else begin
            sync1_q <= key;
            ks_q    <= sync1_q;
        end
    end

    // ---------------- debounce FSM ----------------
    state_e     state_q, state_d;
    logic [9:0] snap_q, snap_d;
    logic [7:0] cnt_q, cnt_d;
    logic       push;
    logic [3:0] snap_code;

    encoder_3cyclic u_enc (
        .keys (snap_q),
        .code (snap_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ks_q != '0) begin
                    state_d = ST_DEBOUNCE;
                    snap_d  = ks_q;
                    cnt_d   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (ks_q == '0) begin
                    state_d = ST_IDLE;
                end else if (ks_q != snap_q) begin
                    // A different chord restarts the stability window.
                    snap_d = ks_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    push    = 1'b1;
                    state_d = ST_HELD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HELD: begin
                // Pattern changes while held never produce another code.
                if (ks_q == '0) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (ks_q != '0) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign key_down = (state_q == ST_HELD) || (state_q == ST_RELEASE);

    // ---------------- code FIFO ----------------
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [3:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0]    count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          pop, full, do_push, ovf_set;

    assign valid   = (count_q != 4'd0);
    assign full    = (count_q == DEPTH_C);
    // Pop only when something is there, so an empty-buffer push is never
    // cancelled by a coincident ready.
    assign pop     = valid && ready;
    // A pop in the same cycle frees the slot a full-buffer push needs.
    assign do_push = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wptr_q] = snap_code;
        wptr_d     = wptr_q + PW'(do_push);
        rptr_d     = rptr_q + PW'(pop);
        count_d    = count_q + 4'(do_push) - 4'(pop);
        overflow_d = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= EMPTY_CODE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign code_out = valid ? mem_q[rptr_q] : EMPTY_CODE;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
